// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   state_e       : arbiter FSM states (IDLE, BUSY)
//   NREQ_DEF      : default number of requesters
//   DATASIZE_DEF  : default word width (matches the FIFO DATASIZE)
//   MAX_BURST_DEF : default maximum words per grant
//   WRCNT_W       : width of the total-words-written counter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned DATASIZE_DEF  = 8;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned WRCNT_W       = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search.
//   req : request vector, one bit per requester
//   ptr : index where the search starts (highest priority)
//   any : at least one request is set
//   idx : first set request found at ptr, ptr+1, ... modulo NREQ
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (!found && req[IW'(cand)]) begin
        idx   = IW'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A grant lasts up to MAX_BURST words; wfull_i stalls a burst, a dropped
// valid ends it. One IDLE cycle always separates consecutive grants.
//   wclk_i, wrst_n_i : write clock, async active-low reset
//   req_valid_i      : per-requester word valid
//   req_data_i       : per-requester word, requester k at [k*DATASIZE +: DATASIZE]
//   req_ready_o      : per-requester accept strobe
//   gnt_o            : one-hot grant, zero when idle
//   wfull_i          : FIFO full
//   winc_o, wdata_o  : FIFO write enable / data
//   busy_o           : high in BUSY
//   wr_cnt_o         : words written since reset (wraps)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned DATASIZE  = DATASIZE_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     wclk_i,
  input  logic                     wrst_n_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DATASIZE-1:0] req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic [NREQ-1:0]          gnt_o,
  input  logic                     wfull_i,
  output logic                     winc_o,
  output logic [DATASIZE-1:0]      wdata_o,
  output logic                     busy_o,
  output logic [WRCNT_W-1:0]       wr_cnt_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_e               state_q;
  logic [IW-1:0]        g_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        rr_ptr_d;
  logic [BW-1:0]        bcnt_q;
  logic [BW-1:0]        bcnt_d;
  logic [WRCNT_W-1:0]   wr_cnt_q;

  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic                 busy;
  logic                 xfer;
  logic                 last_word;
  logic [DATASIZE-1:0]  data_a [NREQ];

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy      = (state_q == BUSY);
  assign xfer      = busy && req_valid_i[g_q] && !wfull_i;
  assign bcnt_d    = bcnt_q + 1'b1;
  assign last_word = (bcnt_d == BW'(MAX_BURST));
  assign rr_ptr_d  = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      state_q  <= IDLE;
      g_q      <= '0;
      bcnt_q   <= '0;
      rr_ptr_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            g_q     <= pick_idx;
            bcnt_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // A dropped valid ends the burst even while the FIFO is full.
          if (!req_valid_i[g_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end else if (!wfull_i) begin
            bcnt_q   <= bcnt_d;
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (last_word) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      data_a[k] = req_data_i[k*DATASIZE +: DATASIZE];
    end
  end

  // Outputs decode from state only (ready ignores valid), so the async
  // reset forcing IDLE clears them immediately.
  always_comb begin
    gnt_o       = '0;
    req_ready_o = '0;
    wdata_o     = '0;
    if (busy) begin
      gnt_o[g_q]       = 1'b1;
      req_ready_o[g_q] = !wfull_i;
      wdata_o          = data_a[g_q];
    end
  end

  assign winc_o   = xfer;
  assign busy_o   = busy;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] data;
  logic        wfull;
  logic [3:0]  ready, gnt;
  logic        winc, busy;
  logic [7:0]  wdata;
  logic [15:0] wr_cnt;

  logic [3:0]  b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_ready, b_gnt;
  logic        b_winc, b_busy;
  logic [7:0]  b_wdata;
  logic [15:0] b_wr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .MAX_BURST(4)) dut (
    .wclk_i(clk), .wrst_n_i(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .gnt_o(gnt), .wfull_i(wfull), .winc_o(winc),
    .wdata_o(wdata), .busy_o(busy), .wr_cnt_o(wr_cnt)
  );

  fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .MAX_BURST(16)) dut16 (
    .wclk_i(clk), .wrst_n_i(rst_n), .req_valid_i(b_valid), .req_data_i(b_data),
    .req_ready_o(b_ready), .gnt_o(b_gnt), .wfull_i(1'b0), .winc_o(b_winc),
    .wdata_o(b_wdata), .busy_o(b_busy), .wr_cnt_o(b_wr_cnt)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        f;
    logic        ew;
    logic [7:0]  ewd;
    logic [3:0]  eg;
    logic [3:0]  er;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic [3:0] v, int k, logic [7:0] b, logic f,
                              logic ew, logic [7:0] ewd, logic [3:0] eg,
                              logic [3:0] er, logic eb, logic [15:0] ec);
    vec_t t;
    t.v = v; t.d = 32'(b) << (k * 8); t.f = f;
    t.ew = ew; t.ewd = ewd; t.eg = eg; t.er = er; t.eb = eb; t.ec = ec;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; valid = '0; data = '0; wfull = 1'b0; b_valid = '0; b_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] bword(int k, int n);
    logic [1:0] kk;
    logic [5:0] nn;
    kk = 2'(k);
    nn = 6'(n);
    return {kk, nn};
  endfunction

  int cnt [4];
  int cur, inb, nxfer, sb_err, cyc, xk;
  logic did;

  initial begin
    // Directed single-cycle table: requester 2 then requester 1 with stalls.
    tbl[0]  = mk(4'h4, 2, 8'h11, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd0);
    tbl[1]  = mk(4'h4, 2, 8'h11, 0, 1, 8'h11, 4'h4, 4'h4, 1, 16'd0);
    tbl[2]  = mk(4'h4, 2, 8'h12, 0, 1, 8'h12, 4'h4, 4'h4, 1, 16'd1);
    tbl[3]  = mk(4'h4, 2, 8'h13, 0, 1, 8'h13, 4'h4, 4'h4, 1, 16'd2);
    tbl[4]  = mk(4'h4, 2, 8'h14, 0, 1, 8'h14, 4'h4, 4'h4, 1, 16'd3);
    tbl[5]  = mk(4'h4, 2, 8'h15, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd4);
    tbl[6]  = mk(4'h4, 2, 8'h15, 0, 1, 8'h15, 4'h4, 4'h4, 1, 16'd4);
    tbl[7]  = mk(4'h4, 2, 8'h16, 0, 1, 8'h16, 4'h4, 4'h4, 1, 16'd5);
    tbl[8]  = mk(4'h0, 2, 8'h16, 0, 0, 8'h16, 4'h4, 4'h4, 1, 16'd6);
    tbl[9]  = mk(4'h0, 2, 8'h16, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd6);
    tbl[10] = mk(4'h2, 1, 8'h21, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd6);
    tbl[11] = mk(4'h2, 1, 8'h21, 0, 1, 8'h21, 4'h2, 4'h2, 1, 16'd6);
    tbl[12] = mk(4'h2, 1, 8'h22, 0, 1, 8'h22, 4'h2, 4'h2, 1, 16'd7);
    tbl[13] = mk(4'h2, 1, 8'h23, 1, 0, 8'h23, 4'h2, 4'h0, 1, 16'd8);
    tbl[14] = mk(4'h2, 1, 8'h23, 1, 0, 8'h23, 4'h2, 4'h0, 1, 16'd8);
    tbl[15] = mk(4'h2, 1, 8'h23, 1, 0, 8'h23, 4'h2, 4'h0, 1, 16'd8);
    tbl[16] = mk(4'h2, 1, 8'h23, 0, 1, 8'h23, 4'h2, 4'h2, 1, 16'd8);
    tbl[17] = mk(4'h2, 1, 8'h24, 0, 1, 8'h24, 4'h2, 4'h2, 1, 16'd9);
    tbl[18] = mk(4'h0, 1, 8'h00, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd10);
    tbl[19] = mk(4'h2, 1, 8'h31, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd10);
    tbl[20] = mk(4'h0, 1, 8'h31, 1, 0, 8'h31, 4'h2, 4'h0, 1, 16'd10);
    tbl[21] = mk(4'h0, 1, 8'h31, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd10);

    // Reset state
    rst_n = 1'b0; valid = '0; data = '0; wfull = 1'b0; b_valid = '0; b_data = '0;
    #3;
    chk("rst_winc", 32'(winc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wrcnt", 32'(wr_cnt), 0);
    reset_dut();

    foreach (tbl[i]) begin
      valid = tbl[i].v; data = tbl[i].d; wfull = tbl[i].f;
      @(negedge clk);
      chk($sformatf("v%0d_winc", i),  32'(winc),   32'(tbl[i].ew));
      chk($sformatf("v%0d_wdata", i), 32'(wdata),  32'(tbl[i].ewd));
      chk($sformatf("v%0d_gnt", i),   32'(gnt),    32'(tbl[i].eg));
      chk($sformatf("v%0d_ready", i), 32'(ready),  32'(tbl[i].er));
      chk($sformatf("v%0d_busy", i),  32'(busy),   32'(tbl[i].eb));
      chk($sformatf("v%0d_wrcnt", i), 32'(wr_cnt), 32'(tbl[i].ec));
      tick();
    end
    valid = '0; wfull = 1'b0;

    // All four requesters valid: grants 0,1,2,3,0 with one-cycle gaps.
    reset_dut();
    valid = 4'hF; data = 32'hA3A2A1A0;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      chk($sformatf("rr_gap%0d", b), 32'({busy, winc}), 0);
      tick();
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk($sformatf("rr_b%0d_w%0d_gnt", b, j), 32'(gnt), 32'(1 << (b % 4)));
        chk($sformatf("rr_b%0d_w%0d_winc", b, j), 32'(winc), 1);
        chk($sformatf("rr_b%0d_w%0d_data", b, j), 32'(wdata), 32'(8'hA0 + b % 4));
        tick();
      end
    end
    valid = '0;

    // Requester 0 drops after 2 words; requester 3 takes over after a gap.
    reset_dut();
    valid = 4'b1001; data = 32'h70000050;
    tick();
    @(negedge clk); chk("drop_w1", 32'({gnt, winc}), 32'({4'h1, 1'b1}));
    tick();
    @(negedge clk); chk("drop_w2", 32'({gnt, winc}), 32'({4'h1, 1'b1}));
    tick();
    valid = 4'b1000;
    @(negedge clk); chk("drop_end", 32'({busy, gnt, winc}), 32'({1'b1, 4'h1, 1'b0}));
    chk("drop_wrcnt", 32'(wr_cnt), 2);
    tick();
    @(negedge clk); chk("drop_idle", 32'({busy, gnt}), 0);
    tick();
    @(negedge clk); chk("drop_gnt3", 32'({gnt, winc, wdata}), 32'({4'h8, 1'b1, 8'h70}));
    tick();
    valid = '0;

    // Reset mid-burst at word 3; arbitration restarts at requester 0.
    reset_dut();
    valid = 4'b0010; data = 32'h00004000;
    repeat (5) tick();
    valid = 4'hF; data = 32'hA3A2A1A0;
    @(negedge clk); chk("mrst_idle", 32'(busy), 0);
    repeat (3) tick();
    @(negedge clk); chk("mrst_w3", 32'({gnt, winc}), 32'({4'h4, 1'b1}));
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_outs", 32'({winc, ready, gnt, busy, wdata}), 0);
    chk("mrst_wrcnt", 32'(wr_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_regnt0", 32'({gnt, winc, wdata}), 32'({4'h1, 1'b1, 8'hA0}));
    chk("mrst_wrcnt_after", 32'(wr_cnt), 0);
    tick();
    valid = '0;

    // 65537 transfers through the 16-word-burst instance, scoreboarded.
    reset_dut();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    cur = 0; inb = 0; nxfer = 0; sb_err = 0; cyc = 0;
    b_valid = 4'hF;
    for (int k = 0; k < 4; k++) b_data[k*8 +: 8] = bword(k, 0);
    while (nxfer < 65537 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      did = b_winc;
      if (b_winc) begin
        if (b_gnt !== 4'(1 << cur) || b_ready !== 4'(1 << cur) ||
            b_wdata !== bword(cur, cnt[cur]))
          sb_err++;
        xk = cur;
        nxfer++;
        inb++;
        if (inb == 16) begin
          inb = 0;
          cur = (cur + 1) % 4;
        end
      end
      tick();
      if (did) begin
        cnt[xk]++;
        b_data[xk*8 +: 8] = bword(xk, cnt[xk]);
      end
      if (nxfer == 65537) b_valid = '0;
    end
    chk("sb_xfers", 32'(nxfer), 65537);
    chk("sb_words", 32'(sb_err), 0);
    @(negedge clk);
    chk("wrcnt_wrap", 32'(b_wr_cnt), 1);
    chk("wrcnt_nowrite", 32'(b_winc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters sharing one FIFO write port.
REQ-002 Parameter DATASIZE, default 8: data word width, equal to the FIFO DATASIZE.
REQ-003 Parameter MAX_BURST, default 4: maximum words per grant (1..16).
REQ-004 wclk_i  in  1  single clock for the block, the FIFO write clock; all state updates on its rising edge.
REQ-005 wrst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i  in  NREQ  per-requester word-valid.
REQ-007 req_data_i  in  NREQ*DATASIZE  per-requester word; requester k occupies bits [k*DATASIZE +: DATASIZE].
REQ-008 req_ready_o  out  NREQ  per-requester accept strobe.
REQ-009 gnt_o  out  NREQ  one-hot current grant; all-zero when idle.
REQ-010 wfull_i  in  1  FIFO full flag, write-domain synchronous.
REQ-011 winc_o  out  1  FIFO write enable.
REQ-012 wdata_o  out  DATASIZE  FIFO write data.
REQ-013 busy_o  out  1  high while in state BUSY.
REQ-014 wr_cnt_o  out  16  total words written since reset.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BUSY, with registers for the state, grant index g, burst count bcnt and round-robin pointer rr_ptr.
REQ-016 In IDLE with any req_valid_i set, the FSM SHALL select the first valid index searching rr_ptr, rr_ptr+1, ... modulo NREQ, load it into g, clear bcnt and enter BUSY next cycle (one-cycle arbitration latency).
REQ-017 In IDLE with no valid requests, the FSM SHALL remain in IDLE.
REQ-018 A transfer SHALL occur in a cycle iff state==BUSY, req_valid_i[g]==1 and wfull_i==0.
REQ-019 req_ready_o[k] = (state==BUSY) & (g==k) & !wfull_i; combinational, with no dependency on req_valid_i.
REQ-020 winc_o SHALL equal the transfer condition combinationally; wdata_o SHALL equal the data of requester g in BUSY and 0 in IDLE.
REQ-021 On each transfer, bcnt SHALL increment and wr_cnt_o SHALL increment, wrapping from 65535 to 0.
REQ-022 BUSY->IDLE SHALL occur after the transfer that makes bcnt==MAX_BURST.
REQ-023 BUSY->IDLE SHALL also occur in any BUSY cycle where req_valid_i[g]==0.
REQ-024 On every BUSY->IDLE transition, rr_ptr SHALL become (g+1) mod NREQ.
REQ-025 wfull_i==1 SHALL stall the burst without ending it: no transfer, and bcnt and state are held.
REQ-026 Valid deassertion while wfull_i==1 SHALL still end the burst per REQ-023.
REQ-027 Exactly one IDLE bubble cycle SHALL separate consecutive grants, including re-grant to the same requester.
REQ-028 gnt_o SHALL be the one-hot decode of g in BUSY and 0 in IDLE.

Reset
REQ-029 wrst_n_i low SHALL immediately force state=IDLE, g=0, bcnt=0, rr_ptr=0 and wr_cnt_o=0.
REQ-030 While wrst_n_i is low, winc_o, req_ready_o, gnt_o, busy_o and wdata_o SHALL all be 0, including when reset is asserted mid-burst; no partial write is emitted.
REQ-031 Arbitration SHALL resume on the first rising wclk_i edge after wrst_n_i is released.

Structure
REQ-032 A shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BUSY), the default NREQ, DATASIZE and MAX_BURST, and the wr_cnt_o width (16).
REQ-033 The round-robin search SHALL be a combinational sub-module rr_picker with inputs req[NREQ] and ptr, and outputs any and idx.

Verification
REQ-034 Reset, then only requester 2 valid with words 0x11..0x16, wfull_i=0 -> gnt_o=0100 one cycle later; 0x11..0x14 written on consecutive cycles; one idle cycle; re-grant writes 0x15,0x16; wr_cnt_o=6.
REQ-035 All four requesters valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; each burst is 4 winc_o pulses followed by a 1-cycle gap.
REQ-036 Requester 1 bursting, wfull_i high for 3 cycles after its 2nd word -> winc_o and req_ready_o low for those 3 cycles; words 3 and 4 follow immediately after; total burst is 4 words.
REQ-037 Requester 0 drops valid after 2 words while requester 3 is valid -> IDLE for one cycle, then gnt_o=1000, rr_ptr=1 before the switch.
REQ-038 wrst_n_i pulsed low mid-burst at word 3 -> winc_o low within the same cycle; after release wr_cnt_o=0, and arbitration restarts from requester 0.
REQ-039 Feed 65537 transfers -> wr_cnt_o=1, and a scoreboard shows every written word matches the requester queue order.
